// File: rtl/numbotron_seq_if.sv
// ROM fetch and register-bank strobe bus of the numbotron program sequencer.
interface numbotron_seq_if #(
    parameter int PC_W = 5
);
    localparam int INSTR_W = PC_W + 4;

    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         reg_z;
    logic [3:0]         reg_inc;
    logic [3:0]         reg_dec;
    logic [3:0]         reg_clr;

    modport master (
        output pc, reg_inc, reg_dec, reg_clr,
        input  instr, reg_z
    );

    modport slave (
        input  pc, reg_inc, reg_dec, reg_clr,
        output instr, reg_z
    );
endinterface

// File: rtl/numbotron_seq.sv
// Counter-machine sequencer (INC/DECJZ/CLR/HALT) driving four NUMReg registers.
// Define NUMSEQ_STEP_EN for single-step mode (step/paused ports, PAUSE state).
module numbotron_seq #(
    parameter int PC_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slowclk,
    input  logic        start,
    input  logic        stop,
`ifdef NUMSEQ_STEP_EN
    input  logic        step,
    output logic        paused,
`endif
    output logic        busy,
    output logic        halted,
    output logic [15:0] icount,
    numbotron_seq_if.master bus
);
    localparam int INSTR_W = PC_W + 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HALT
`ifdef NUMSEQ_STEP_EN
        , S_PAUSE
`endif
    } state_e;

`ifdef NUMSEQ_STEP_EN
    localparam state_e S_NEXT = S_PAUSE;
`else
    localparam state_e S_NEXT = S_FETCH;
`endif

    localparam logic [1:0] OP_INC   = 2'b00;
    localparam logic [1:0] OP_DECJZ = 2'b01;
    localparam logic [1:0] OP_CLR   = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ld_q, ld_d;
    logic [15:0]        icount_q, icount_d;

    logic [INSTR_W-1:0] cur;
    logic [1:0]         op;
    logic [1:0]         sel;
    logic [PC_W-1:0]    tgt;
    logic [PC_W-1:0]    pc_inc;
    logic               tick;
    logic [3:0]         inc_s, dec_s, clr_s;

    // ROM data only becomes valid in the first WAIT cycle, so decode it
    // directly then and from ir afterwards.
    assign cur    = ld_q ? bus.instr : ir_q;
    assign op     = cur[INSTR_W-1 -: 2];
    assign sel    = cur[INSTR_W-3 -: 2];
    assign tgt    = cur[PC_W-1:0];
    assign pc_inc = PC_W'(pc_q + 1'b1);
    assign tick   = (state_q == S_WAIT) & slowclk & ~stop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            ld_q     <= 1'b0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ld_q     <= ld_d;
            icount_q <= icount_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ld_d     = 1'b0;
        icount_d = icount_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    ld_d    = 1'b1;
                end
            end
            S_WAIT: begin
                if (ld_q) ir_d = bus.instr;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (slowclk) begin
                    if (icount_q != 16'hFFFF) icount_d = icount_q + 16'd1;
                    state_d = S_NEXT;
                    unique case (op)
                        OP_INC:   pc_d = pc_inc;
                        OP_DECJZ: pc_d = bus.reg_z[sel] ? tgt : pc_inc;
                        OP_CLR:   pc_d = pc_inc;
                        OP_HALT:  state_d = S_HALT;
                    endcase
                end
            end
            S_HALT: begin
                if (stop) state_d = S_IDLE;
                else if (start) state_d = S_FETCH;
            end
`ifdef NUMSEQ_STEP_EN
            S_PAUSE: begin
                if (stop) state_d = S_IDLE;
                else if (step) state_d = S_FETCH;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        inc_s = '0;
        dec_s = '0;
        clr_s = '0;
        if (tick) begin
            unique case (op)
                OP_INC:   inc_s[sel] = 1'b1;
                OP_DECJZ: dec_s[sel] = ~bus.reg_z[sel];
                OP_CLR:   clr_s[sel] = 1'b1;
                OP_HALT:  ;
            endcase
        end
    end

    assign bus.reg_inc = inc_s;
    assign bus.reg_dec = dec_s;
    assign bus.reg_clr = clr_s;
    assign bus.pc      = pc_q;
    assign busy        = (state_q == S_FETCH) | (state_q == S_WAIT);
    assign halted      = (state_q == S_HALT);
    assign icount      = icount_q;
`ifdef NUMSEQ_STEP_EN
    assign paused      = (state_q == S_PAUSE);
`endif
endmodule

// File: tb/tb_numbotron_seq.sv
// Bench for numbotron_seq: directed scenarios plus random programs
// checked against a program-level interpreter of the counter machine.
module tb_numbotron_seq;
    localparam int PC_W = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        slowclk = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        busy;
    logic        halted;
    logic [15:0] icount;
`ifdef NUMSEQ_STEP_EN
    logic        step = 1'b0;
    logic        paused;
`endif

    int checks = 0;
    int failures = 0;

    numbotron_seq_if #(.PC_W(PC_W)) bus ();

    numbotron_seq #(.PC_W(PC_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .slowclk (slowclk),
        .start   (start),
        .stop    (stop),
`ifdef NUMSEQ_STEP_EN
        .step    (step),
        .paused  (paused),
`endif
        .busy    (busy),
        .halted  (halted),
        .icount  (icount),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [8:0] rom [32];

    always @(posedge clk) bus.instr <= rom[bus.pc];

    // Interpreter state: program counter, register values, counters.
    int          m_r [4];
    logic [4:0]  m_pc;
    logic [15:0] m_ic;
    bit          m_halt;

    function automatic logic [8:0] enc(input logic [1:0] op,
                                       input logic [1:0] r,
                                       input logic [4:0] t);
        return {op, r, t};
    endfunction

    task automatic model_exec(output logic [11:0] e);
        logic [8:0] w;
        logic [1:0] op;
        int         s;
        for (int i = 0; i < 4; i++) bus.reg_z[i] = (m_r[i] == 0);
        w  = rom[m_pc];
        op = w[8:7];
        s  = int'(w[6:5]);
        e  = '0;
        case (op)
            2'd0: begin e[s] = 1'b1; m_r[s]++; m_pc++; end
            2'd1: begin
                if (m_r[s] == 0) m_pc = w[4:0];
                else begin e[4+s] = 1'b1; m_r[s]--; m_pc++; end
            end
            2'd2: begin e[8+s] = 1'b1; m_r[s] = 0; m_pc++; end
            default: m_halt = 1'b1;
        endcase
        if (m_ic != 16'hFFFF) m_ic++;
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_ic = '0;
        m_halt = 1'b0;
    endtask

    task automatic fill_rom_halt();
        for (int i = 0; i < 32; i++) rom[i] = enc(2'd3, 2'd0, 5'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_halt = 1'b0;
    endtask

    task automatic raw_tick(output logic [11:0] obs);
        @(posedge clk); #1 slowclk = 1'b1;
        @(negedge clk);
        obs = {bus.reg_clr, bus.reg_dec, bus.reg_inc};
        @(posedge clk); #1 slowclk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_tick(output logic [11:0] obs);
        raw_tick(obs);
`ifdef NUMSEQ_STEP_EN
        if (!m_halt) begin
            step = 1'b1;
            @(posedge clk); #1 step = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
`endif
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.pc !== 5'd0) begin
            failures++;
            $display("FAIL reset_pc got=%0d exp=0", bus.pc);
        end
        checks++;
        if (icount !== 16'd0) begin
            failures++;
            $display("FAIL reset_icount got=%0d exp=0", icount);
        end
        checks++;
        if ({busy, halted} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00", {busy, halted});
        end
        checks++;
        if ({bus.reg_clr, bus.reg_dec, bus.reg_inc} !== 12'h0) begin
            failures++;
            $display("FAIL reset_strobes got=%h exp=000",
                     {bus.reg_clr, bus.reg_dec, bus.reg_inc});
        end
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_inc_halt();
        logic [11:0] e, obs;
        fill_rom_halt();
        rom[0] = enc(2'd0, 2'd0, 5'd0);
        rom[1] = enc(2'd0, 2'd0, 5'd0);
        m_r = '{0, 0, 0, 0};
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            model_exec(e);
            do_tick(obs);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL inc_halt_strobe%0d got=%h exp=%h", i, obs, e);
            end
        end
        checks++;
        if ({halted, busy, icount, bus.pc} !== {2'b10, 16'd3, 5'd2}) begin
            failures++;
            $display("FAIL inc_halt_end got=h%0d b%0d ic%0d pc%0d exp=h1 b0 ic3 pc2",
                     halted, busy, icount, bus.pc);
        end
        pulse_start();
        model_exec(e);
        do_tick(obs);
        checks++;
        if ({obs, halted, icount, bus.pc} !== {12'h0, 1'b1, 16'd4, 5'd2}) begin
            failures++;
            $display("FAIL halt_restart got=%h h%0d ic%0d pc%0d exp=000 h1 ic4 pc2",
                     obs, halted, icount, bus.pc);
        end
    endtask

    task automatic test_decjz(input bit zero_r1);
        logic [11:0] e, obs;
        fill_rom_halt();
        rom[0] = enc(2'd1, 2'd1, 5'd3);
        rom[1] = enc(2'd1, 2'd2, 5'd0);
        rom[3] = enc(2'd3, 2'd0, 5'd0);
        if (zero_r1) m_r = '{3, 0, 3, 3};
        else m_r = '{2, 2, 2, 2};
        do_reset();
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            model_exec(e);
            do_tick(obs);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL decjz%0d_strobe%0d got=%h exp=%h",
                         zero_r1, i, obs, e);
            end
            checks++;
            if (bus.pc !== m_pc) begin
                failures++;
                $display("FAIL decjz%0d_pc%0d got=%0d exp=%0d",
                         zero_r1, i, bus.pc, m_pc);
            end
        end
        checks++;
        if ({halted, icount} !== {m_halt, m_ic}) begin
            failures++;
            $display("FAIL decjz%0d_end got=h%0d ic%0d exp=h%0d ic%0d",
                     zero_r1, halted, icount, m_halt, m_ic);
        end
    endtask

    task automatic test_stop_tick();
        logic [11:0] e, obs;
        fill_rom_halt();
        rom[0] = enc(2'd0, 2'd3, 5'd0);
        m_r = '{0, 0, 0, 0};
        do_reset();
        pulse_start();
        @(posedge clk); #1 slowclk = 1'b1; stop = 1'b1;
        @(negedge clk);
        obs = {bus.reg_clr, bus.reg_dec, bus.reg_inc};
        @(posedge clk); #1 slowclk = 1'b0; stop = 1'b0;
        checks++;
        if (obs !== 12'h0) begin
            failures++;
            $display("FAIL stop_tick_strobe got=%h exp=000", obs);
        end
        checks++;
        if ({busy, halted, bus.pc, icount} !== {2'b00, 5'd0, 16'd0}) begin
            failures++;
            $display("FAIL stop_tick_state got=b%0d h%0d pc%0d ic%0d exp=0 0 0 0",
                     busy, halted, bus.pc, icount);
        end
        pulse_start();
        model_exec(e);
        do_tick(obs);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL stop_resume got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_stop_wins();
        do_reset();
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_wins got=%0d exp=0", busy);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] e, obs;
        fill_rom_halt();
        rom[0]  = enc(2'd1, 2'd0, 5'd31);
        rom[31] = enc(2'd0, 2'd0, 5'd0);
        m_r = '{0, 0, 0, 0};
        do_reset();
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            model_exec(e);
            do_tick(obs);
            checks++;
            if ({obs, bus.pc} !== {e, m_pc}) begin
                failures++;
                $display("FAIL wrap%0d got=%h pc%0d exp=%h pc%0d",
                         i, obs, bus.pc, e, m_pc);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e, obs;
        fill_rom_halt();
        rom[0] = enc(2'd0, 2'd1, 5'd0);
        rom[1] = enc(2'd0, 2'd2, 5'd0);
        m_r = '{0, 0, 0, 0};
        do_reset();
        pulse_start();
        model_exec(e);
        do_tick(obs);
        @(posedge clk); #1 slowclk = 1'b1;
        #1;
        checks++;
        if ({bus.reg_clr, bus.reg_dec, bus.reg_inc} !== 12'h004) begin
            failures++;
            $display("FAIL reset_mid_pre got=%h exp=004",
                     {bus.reg_clr, bus.reg_dec, bus.reg_inc});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.reg_clr, bus.reg_dec, bus.reg_inc, bus.pc, icount}
            !== {12'h0, 5'd0, 16'd0}) begin
            failures++;
            $display("FAIL reset_mid got=%h pc%0d ic%0d exp=000 pc0 ic0",
                     {bus.reg_clr, bus.reg_dec, bus.reg_inc}, bus.pc, icount);
        end
        @(posedge clk); #1 reset = 1'b0; slowclk = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [11:0] e, obs;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 32; i++) rom[i] = 9'($urandom);
            for (int i = 0; i < 4; i++) m_r[i] = int'($urandom_range(0, 2));
            do_reset();
            pulse_start();
            for (int t = 0; t < 24; t++) begin
                if (m_halt) pulse_start();
                model_exec(e);
                do_tick(obs);
                checks++;
                if ({obs, bus.pc, icount, halted} !== {e, m_pc, m_ic, m_halt}) begin
                    failures++;
                    $display("FAIL random r%0d t%0d got=%h pc%0d ic%0d h%0d exp=%h pc%0d ic%0d h%0d",
                             r, t, obs, bus.pc, icount, halted,
                             e, m_pc, m_ic, m_halt);
                end
            end
        end
    endtask

`ifdef NUMSEQ_STEP_EN
    task automatic test_step();
        logic [11:0] e, obs;
        fill_rom_halt();
        for (int i = 0; i < 3; i++) rom[i] = enc(2'd0, 2'd0, 5'd0);
        m_r = '{0, 0, 0, 0};
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            model_exec(e);
            raw_tick(obs);
            checks++;
            if ({obs, paused, busy} !== {e, 2'b10}) begin
                failures++;
                $display("FAIL step_tick%0d got=%h p%0d b%0d exp=%h p1 b0",
                         i, obs, paused, busy, e);
            end
            raw_tick(obs);
            checks++;
            if ({obs, paused} !== {12'h0, 1'b1}) begin
                failures++;
                $display("FAIL step_hold%0d got=%h p%0d exp=000 p1", i, obs, paused);
            end
            step = 1'b1;
            @(posedge clk); #1 step = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
        model_exec(e);
        raw_tick(obs);
        checks++;
        if ({halted, paused, icount} !== {2'b10, 16'd4}) begin
            failures++;
            $display("FAIL step_halt got=h%0d p%0d ic%0d exp=h1 p0 ic4",
                     halted, paused, icount);
        end
    endtask
`endif

    initial begin
        bus.reg_z = 4'h0;
        fill_rom_halt();
        test_reset();
        test_inc_halt();
        test_decjz(1'b1);
        test_decjz(1'b0);
        test_stop_tick();
        test_stop_wins();
        test_wrap();
        test_reset_mid();
`ifdef NUMSEQ_STEP_EN
        test_step();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/numbotron_seq.md
Name: numbotron_seq

Overview:
Program sequencer for the numbotron register bank. Executes a small counter-machine program: INC, DECJZ (decrement, or jump when the register is zero), CLR and HALT. It targets four NUMReg registers. Each instruction word is fetched from a synchronous program ROM. Per-register inc/dec/clear strobes are issued aligned to the slowclk tick, and each register's reg_z flag is sampled for branching.

Parameters:
PC_W, 5, program counter width; program depth 2^PC_W words
INSTR_W, PC_W+4, instruction width: [INSTR_W-1:INSTR_W-2] opcode, [INSTR_W-3:INSTR_W-4] register select, [PC_W-1:0] jump target

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
slowclk  in  1  one-clk-wide execution tick, same as the one fed to NUMReg
start  in  1  pulse; begin execution from the current pc
stop  in  1  pulse; abort to IDLE
pc  out  PC_W  program ROM address
instr  in  INSTR_W  ROM data, valid one clk after pc changes
reg_z  in  4  zero flags of registers 3..0
reg_inc  out  4  per-register increment strobe
reg_dec  out  4  per-register decrement strobe
reg_clr  out  4  per-register clear strobe, to NUMReg reg_reset
busy  out  1  high in FETCH/WAIT_TICK
halted  out  1  high in HALT
icount  out  16  executed-instruction count, saturating at 16'hFFFF

Behaviour:
- Opcodes: 00 INC, 01 DECJZ, 10 CLR, 11 HALT.
- Reset (async): state=IDLE, pc=0, icount=0, ir=0, busy=0, halted=0. All strobes are 0 immediately because they are combinational from reset state.
- State IDLE:
  - start=1 & stop=0 -> FETCH.
  - stop always wins over start.
- State FETCH: one cycle for ROM latency. Next cycle latch instr into ir and go to WAIT_TICK.
- State WAIT_TICK: hold until slowclk=1. In the tick cycle, sel=ir register field:
  - INC: reg_inc[sel]=1; pc<=pc+1.
  - DECJZ with reg_z[sel]=1: no strobe; pc<=target.
  - DECJZ with reg_z[sel]=0: reg_dec[sel]=1; pc<=pc+1.
  - CLR: reg_clr[sel]=1; pc<=pc+1.
  - HALT: no strobe; pc unchanged; -> HALT.
  - Non-HALT ops then -> FETCH. icount increments on every tick-executed instruction, including HALT.
- Strobes = (state==WAIT_TICK) & slowclk & ~stop & decode(ir). They are exactly one clk wide, one-hot across all 12 bits, and coincide with slowclk. NUMReg carry ripple therefore completes in the same tick.
- reg_z is sampled only in the tick cycle. It reflects the register state before that tick's update.
- pc+1 wraps modulo 2^PC_W (all-ones -> 0). The jump target is taken verbatim.
- State HALT: halted=1, busy=0.
  - start -> FETCH with pc unchanged, so it re-executes HALT unless pc was changed by external reset.
  - stop -> IDLE.
- stop in FETCH/WAIT_TICK: -> IDLE next cycle. No strobe in the stop cycle. pc and icount are retained.
- reset mid-instruction: any pending strobe is suppressed at once.
- icount holds at 16'hFFFF once saturated.

Optional Feature:
NUMSEQ_STEP_EN:
- Defined: adds input `step` (1 bit) and output `paused` (1 bit), plus state PAUSE.
  - Each non-HALT instruction tick goes to PAUSE instead of FETCH.
  - PAUSE -> FETCH on step=1; PAUSE -> IDLE on stop. stop wins over step.
  - paused=1 only in PAUSE; busy=0 in PAUSE.
- Undefined: no step/paused ports and no PAUSE state; execution is free-running.

Test Plan:
- Program {0: INC r0, 1: INC r0, 2: HALT}, start, ticks every 8 clk -> reg_inc[0] pulses on exactly the 1st and 2nd ticks; halted=1 after the 3rd tick; icount=3; pc=2.
- Program {0: DECJZ r1 ->3, 1: DECJZ r2 ->0, 3: HALT} with reg_z=4'b0010 -> no dec strobe at pc0, pc jumps to 3, halted; icount=2.
- Same program with reg_z=4'b0000 -> reg_dec[1] single pulse, pc=1 next; at pc1 reg_dec[2] pulse, pc=0.
- stop asserted in the same cycle as slowclk in WAIT_TICK for INC r3 -> no reg_inc pulse; state IDLE; pc unchanged; icount unchanged.
- PC_W=5, INC r0 placed at pc=31 -> pc wraps to 0. Separately, reset asserted mid-WAIT_TICK with slowclk=1 -> all strobes 0 in that cycle; pc=0; icount=0.
- NUMSEQ_STEP_EN: 3-INC program -> after each tick paused=1 and no further strobes until a step pulse; 3 step pulses reach HALT.
